// File: rtl/svm_sched_defs.sv
// Shared encodings and defaults for the SVM classifier sequencer.
package svm_sched_defs;
  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    CAPT = 2'd3
  } state_t;

  localparam logic [1:0] CLS_NONE = 2'b00;
  localparam logic [1:0] CLS_POS  = 2'b01;
  localparam logic [1:0] CLS_NEG  = 2'b10;

  localparam int N_FEAT_DEF = 10;
  localparam int FV_W_DEF   = 7;
  localparam int SLOT       = 4;

  // RUN spans every feature slot plus two drain cycles of the classifier.
  function automatic int run_len(input int n_feat);
    return SLOT * n_feat + 2;
  endfunction
endpackage

// File: rtl/svm_fv_buffer.sv
// Feature-vector register file: write pointer advances per beat, clr rewinds it,
// read port is combinational for streaming into the classifier.
module svm_fv_buffer #(
  parameter int N_FEAT = 10,
  parameter int FV_W   = 7,
  parameter int FILL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [FV_W-1:0]   wr_data,
  input  logic              clr,
  output logic [FILL_W-1:0] fill,
  input  logic [3:0]        rd_idx,
  output logic [FV_W-1:0]   rd_data
);
  logic [N_FEAT-1:0][FV_W-1:0] buf_q, buf_d;
  logic [FILL_W-1:0]           fill_q, fill_d;

  always_comb begin
    buf_d  = buf_q;
    fill_d = fill_q;
    if (clr) begin
      fill_d = '0;
    end else if (wr_en) begin
      for (int i = 0; i < N_FEAT; i++) begin
        if (fill_q == FILL_W'(i)) buf_d[i] = wr_data;
      end
      fill_d = fill_q + FILL_W'(1);
    end
  end

  // Indices past the last feature read back as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < N_FEAT; i++) begin
      if (rd_idx == 4'(i)) rd_data = buf_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q  <= '0;
      fill_q <= '0;
    end else begin
      buf_q  <= buf_d;
      fill_q <= fill_d;
    end
  end

  assign fill = fill_q;
endmodule

// File: rtl/svm_scheduler.sv
// Sequencer between feature extraction and the linear SVM: buffer a vector,
// reset the classifier, stream features in 4-cycle slots, return the class.
module svm_scheduler
  import svm_sched_defs::*;
#(
  parameter int N_FEAT = N_FEAT_DEF,
  parameter int FV_W   = FV_W_DEF
) (
  input  logic            work_clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [FV_W-1:0] in_data,
  output logic            in_ready,
  output logic            svm_rst_n,
  output logic [FV_W-1:0] svm_fv,
  output logic            svm_fv_f,
  input  logic [1:0]      svm_res,
  input  logic            svm_res_f,
  output logic            out_valid,
  output logic [1:0]      out_class,
  input  logic            out_ready,
  output logic            busy,
  output logic            err
);
  localparam int RUN_LEN = run_len(N_FEAT);
  localparam int CNT_W   = 7;
  localparam int FILL_W  = $clog2(N_FEAT + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic             svm_rst_n_q, svm_rst_n_d;
  logic             svm_fv_f_q, svm_fv_f_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       out_class_q, out_class_d;
  logic             err_q, err_d;

  logic [FILL_W-1:0] fill;
  logic [FV_W-1:0]   rd_data;
  logic              accept, buf_clr, full_next, slot_free;

  // svm_rst_n_q is low only in reset and CLR, so it also blocks the first
  // post-reset cycle from accepting beats.
  assign in_ready  = (state_q == LOAD) && svm_rst_n_q && (fill != FILL_W'(N_FEAT));
  assign accept    = in_valid && in_ready;
  assign full_next = accept ? (fill == FILL_W'(N_FEAT - 1)) : (fill == FILL_W'(N_FEAT));
  assign slot_free = !out_valid_q || out_ready;

  svm_fv_buffer #(
    .N_FEAT (N_FEAT),
    .FV_W   (FV_W),
    .FILL_W (FILL_W)
  ) u_buf (
    .clk     (work_clk),
    .rst     (rst),
    .wr_en   (accept),
    .wr_data (in_data),
    .clr     (buf_clr),
    .fill    (fill),
    .rd_idx  (run_cnt_q[5:2]),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d     = state_q;
    run_cnt_d   = '0;
    buf_clr     = 1'b0;
    out_valid_d = out_valid_q && !out_ready;
    out_class_d = out_class_q;
    err_d       = err_q;
    case (state_q)
      LOAD: begin
        // The last beat and the slot check share an edge so a free slot
        // costs no idle cycle between vectors.
        if (full_next && slot_free) state_d = CLR;
      end
      CLR: begin
        buf_clr = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        run_cnt_d = run_cnt_q + CNT_W'(1);
        if (run_cnt_q == CNT_W'(RUN_LEN - 1)) begin
          state_d   = CAPT;
          run_cnt_d = '0;
        end
      end
      CAPT: begin
        out_valid_d = 1'b1;
        out_class_d = svm_res_f ? svm_res : CLS_NONE;
        if (!svm_res_f) err_d = 1'b1;
        state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
    svm_rst_n_d = (state_d != CLR);
    svm_fv_f_d  = (state_d == RUN);
  end

  always_ff @(posedge work_clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      run_cnt_q   <= '0;
      svm_rst_n_q <= 1'b0;
      svm_fv_f_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_class_q <= CLS_NONE;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_cnt_q   <= run_cnt_d;
      svm_rst_n_q <= svm_rst_n_d;
      svm_fv_f_q  <= svm_fv_f_d;
      out_valid_q <= out_valid_d;
      out_class_q <= out_class_d;
      err_q       <= err_d;
    end
  end

  assign svm_fv    = (state_q == RUN && run_cnt_q < CNT_W'(SLOT * N_FEAT)) ? rd_data : '0;
  assign svm_rst_n = svm_rst_n_q;
  assign svm_fv_f  = svm_fv_f_q;
  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign err       = err_q;
  assign busy      = (state_q != LOAD);
endmodule

// File: tb/tb_svm_scheduler.sv
// Bench for svm_scheduler: classifier model, result scoreboard, vector table,
// handshake/overlap/timeout/reset corner sequences and a randomized phase.
module tb_svm_scheduler;
  import svm_sched_defs::*;

  localparam int N  = 10;
  localparam int W  = 7;
  localparam int RL = 4 * N + 2;

  typedef logic [N-1:0][W-1:0] feat_t;
  typedef struct {
    feat_t      f;
    logic       en;
    int         hold;
    logic [1:0] exp_cls;
  } vec_t;

  logic         clk = 1'b0, rst = 1'b1;
  logic         in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready, svm_rst_n, svm_fv_f, out_valid, busy, err;
  logic [W-1:0] svm_fv;
  logic [1:0]   svm_res, out_class;
  logic         svm_res_f = 1'b0;

  int tests = 0, fails = 0, cyc = 0, acc_cyc = 0;
  logic cls_en = 1'b1, rnd_rdy = 1'b0;
  logic [1:0] exp_q[$];
  feat_t      fv_q[$];
  vec_t       tbl[7];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  svm_scheduler #(.N_FEAT(N), .FV_W(W)) dut (
    .work_clk (clk),       .rst       (rst),
    .in_valid (in_valid),  .in_data   (in_data),  .in_ready  (in_ready),
    .svm_rst_n(svm_rst_n), .svm_fv    (svm_fv),   .svm_fv_f  (svm_fv_f),
    .svm_res  (svm_res),   .svm_res_f (svm_res_f),
    .out_valid(out_valid), .out_class (out_class), .out_ready(out_ready),
    .busy     (busy),      .err       (err)
  );

  function automatic int sum_of(input feat_t f);
    int s = 0;
    for (int k = 0; k < N; k++) s += int'(f[k]);
    return s;
  endfunction

  // Reference decision: small feature totals are positive.
  function automatic logic [1:0] cls_of(input feat_t f, input logic en);
    if (!en) return CLS_NONE;
    return (sum_of(f) < 400) ? CLS_POS : CLS_NEG;
  endfunction

  function automatic feat_t mk(input int base, input int step);
    feat_t f;
    for (int k = 0; k < N; k++) f[k] = W'(base + step * k);
    return f;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Classifier model: counter restarts under svm_rst_n, latches at 4k+1.
  int    cl_cnt = 0;
  feat_t cl_lat = '0;
  always @(posedge clk) begin
    if (!svm_rst_n) begin
      cl_cnt    <= 0;
      svm_res_f <= 1'b0;
    end else if (svm_fv_f) begin
      cl_cnt <= cl_cnt + 1;
      if (cl_cnt < 4 * N && cl_cnt % 4 == 1) cl_lat[cl_cnt / 4] <= svm_fv;
      if (cl_cnt == RL - 1) svm_res_f <= cls_en;
    end
  end
  assign svm_res = (sum_of(cl_lat) < 400) ? CLS_POS : CLS_NEG;

  initial forever begin
    @(negedge clk);
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: pulse widths, feature stream, output stability, scoreboard, err.
  initial begin
    int rstn_low = 0, fvf_len = 0;
    logic prev_ov = 1'b0, prev_or = 1'b0, err_model = 1'b0;
    logic [1:0] prev_cls = '0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        rstn_low = 0; fvf_len = 0; prev_ov = 1'b0; prev_or = 1'b0; err_model = 1'b0;
      end else begin
        if (!svm_rst_n) rstn_low++;
        else if (rstn_low != 0) begin chk("svm_rst_n low cycles", rstn_low, 1); rstn_low = 0; end
        if (svm_fv_f) fvf_len++;
        else if (fvf_len != 0) begin chk("svm_fv_f high cycles", fvf_len, RL); fvf_len = 0; end
        if (svm_fv_f && cl_cnt == RL - 1) begin
          if (fv_q.size() == 0) chk("unexpected run", 1, 0);
          else chk("features latched by classifier", cl_lat, fv_q.pop_front());
        end
        if (prev_ov && !prev_or) begin
          chk("out_valid held", out_valid, 1);
          chk("out_class held", out_class, prev_cls);
        end
        if (out_valid && !prev_ov) begin
          if (exp_q.size() != 0 && exp_q[0] == CLS_NONE) err_model = 1'b1;
          chk("err flag", err, err_model);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("unexpected result", 1, 0);
          else chk("out_class vs model", out_class, exp_q.pop_front());
        end
        prev_ov = out_valid; prev_or = out_ready; prev_cls = out_class;
      end
    end
  end

  task automatic send_beat(input logic [W-1:0] d);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && t < 500) begin @(negedge clk); t++; end
    if (t >= 500) chk("in_ready timeout", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_vector(input feat_t f, input int gap_max);
    for (int k = 0; k < N; k++) begin
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
      send_beat(f[k]);
    end
    acc_cyc = cyc;
    exp_q.push_back(cls_of(f, cls_en));
    fv_q.push_back(f);
    chk("in_ready low after last beat", in_ready, 0);
  endtask

  task automatic wait_result(input logic [1:0] exp, input int hold, input logic do_lat);
    int t = 0;
    while (!out_valid && t < 300) begin @(negedge clk); t++; end
    chk("out_valid arrives", out_valid, 1);
    if (do_lat) chk("result latency", cyc - acc_cyc, 4 * N + 4);
    chk("out_class", out_class, exp);
    repeat (hold) begin
      @(negedge clk);
      chk("out_valid stalled", out_valid, 1);
      chk("out_class stalled", out_class, exp);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid clears after handshake", out_valid, 0);
  endtask

  initial begin
    feat_t f;
    int t, mx;
    tbl[0] = '{mk(1, 1),     1'b1, 0,  CLS_POS};
    tbl[1] = '{mk(127, 0),   1'b1, 20, CLS_NEG};
    tbl[2] = '{mk(0, 0),     1'b1, 3,  CLS_POS};
    tbl[3] = '{mk(39, 0),    1'b1, 1,  CLS_POS};
    tbl[4] = '{mk(40, 0),    1'b1, 0,  CLS_NEG};
    tbl[5] = '{mk(5, 12),    1'b1, 2,  CLS_NEG};
    tbl[6] = '{mk(120, -13), 1'b1, 0,  CLS_NEG};

    repeat (3) @(negedge clk);
    chk("rst in_ready", in_ready, 0);
    chk("rst svm_rst_n", svm_rst_n, 0);
    chk("rst svm_fv_f", svm_fv_f, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_class", out_class, 0);
    chk("rst err", err, 0);
    chk("rst busy", busy, 0);
    rst = 1'b0;
    #1 chk("svm_rst_n before first edge", svm_rst_n, 0);
    @(negedge clk);
    chk("svm_rst_n after release", svm_rst_n, 1);
    chk("in_ready after release", in_ready, 1);

    for (int i = 0; i < 7; i++) begin
      cls_en = tbl[i].en;
      send_vector(tbl[i].f, 0);
      wait_result(tbl[i].exp_cls, tbl[i].hold, 1'b1);
    end

    // Second vector loaded while the first result is still pending.
    send_vector(mk(10, 3), 0);
    t = 0;
    while (!out_valid && t < 300) begin @(negedge clk); t++; end
    chk("first result pending", out_valid, 1);
    send_vector(mk(90, 4), 0);
    repeat (5) begin
      @(negedge clk);
      chk("stall svm_fv_f", svm_fv_f, 0);
      chk("stall svm_rst_n", svm_rst_n, 1);
      chk("stall busy", busy, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("CLR follows freed slot", svm_rst_n, 0);
    chk("busy in CLR", busy, 1);
    chk("out_valid cleared", out_valid, 0);
    wait_result(CLS_NEG, 0, 1'b0);

    rnd_rdy = 1'b1;
    repeat (8) begin
      mx = $urandom_range(10, 127);
      for (int k = 0; k < N; k++) f[k] = W'($urandom_range(0, mx));
      send_vector(f, 3);
    end
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 3000) begin @(negedge clk); t++; end
    chk("random results drained", exp_q.size(), 0);
    rnd_rdy = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;

    // Classifier never flags a result.
    cls_en = 1'b0;
    send_vector(mk(7, 1), 0);
    wait_result(CLS_NONE, 0, 1'b1);
    chk("err set on timeout", err, 1);
    cls_en = 1'b1;
    send_vector(mk(2, 2), 0);
    wait_result(CLS_POS, 0, 1'b1);
    chk("err sticky", err, 1);

    // Abort mid-run.
    send_vector(mk(50, 1), 0);
    t = 0;
    while (!(svm_fv_f && cl_cnt == 20) && t < 200) begin @(negedge clk); t++; end
    chk("reached run_cnt 20", cl_cnt, 20);
    rst = 1'b1;
    #1;
    chk("abort svm_fv_f", svm_fv_f, 0);
    chk("abort svm_rst_n", svm_rst_n, 0);
    chk("abort busy", busy, 0);
    chk("abort in_ready", in_ready, 0);
    chk("abort err cleared", err, 0);
    exp_q.delete();
    fv_q.delete();
    repeat (3) begin @(negedge clk); chk("no out_valid in reset", out_valid, 0); end
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready after abort", in_ready, 1);
    send_vector(mk(4, 9), 0);
    wait_result(CLS_NEG, 0, 1'b1);
    chk("err after abort", err, 0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
